// File: rtl/alu_iter_exec_if.sv
// rtl/alu_iter_exec_if.sv - operand/result handshake bundle for the iterative ALU execute stage
interface alu_iter_exec_if #(parameter int WIDTH = 32);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             lt_s;
    logic             lt_u;
    logic             illegal;

    modport master (
        output in_valid, op, a, b, out_ready,
        input  in_ready, out_valid, result, zero, lt_s, lt_u, illegal
    );

    modport slave (
        input  in_valid, op, a, b, out_ready,
        output in_ready, out_valid, result, zero, lt_s, lt_u, illegal
    );
endinterface

// File: rtl/alu_iter_exec.sv
// rtl/alu_iter_exec.sv - execute stage with single-cycle logic/arith ops and bit-serial shifts
module alu_iter_exec #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic           clk,
    input  logic           rst_n,
    alu_iter_exec_if.slave bus
);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state, state_n;
    logic [WIDTH-1:0] res_q;
    logic [3:0]       op_q;
    logic [SHW-1:0]   cnt_q;
    logic             lt_s_q, lt_u_q, ill_q;

    logic             accept, is_shift, legal, lt_s_n, lt_u_n;
    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] alu_val;

    assign accept   = bus.in_valid && (state == IDLE);
    assign shamt    = bus.b[SHW-1:0];
    assign lt_s_n   = $signed(bus.a) < $signed(bus.b);
    assign lt_u_n   = bus.a < bus.b;
    assign is_shift = (bus.op == 4'b0100) || (bus.op == 4'b1000) || (bus.op == 4'b1100);

    always_comb begin
        alu_val = '0;
        legal   = 1'b1;
        case (bus.op)
            4'b0000: alu_val = bus.a & bus.b;
            4'b0001: alu_val = bus.a | bus.b;
            4'b0010: alu_val = bus.a + bus.b;
            4'b0011: alu_val = bus.a ^ bus.b;
            4'b0101: alu_val = {{(WIDTH-1){1'b0}}, lt_u_n};
            4'b0110,
            4'b0111: alu_val = bus.a - bus.b;
            4'b1010: alu_val = {{(WIDTH-1){1'b0}}, lt_s_n};
            4'b0100,
            4'b1000,
            4'b1100: alu_val = '0;
            default: legal = 1'b0;
        endcase
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:  if (accept) state_n = (is_shift && shamt != '0) ? SHIFT : DONE;
            SHIFT: if (cnt_q == SHW'(1)) state_n = DONE;
            DONE:  if (bus.out_ready) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    // res_q doubles as the shift register while in SHIFT; a zero shift loads a and finishes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_q  <= '0;
            op_q   <= '0;
            cnt_q  <= '0;
            lt_s_q <= 1'b0;
            lt_u_q <= 1'b0;
            ill_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    op_q   <= bus.op;
                    cnt_q  <= shamt;
                    lt_s_q <= lt_s_n;
                    lt_u_q <= lt_u_n;
                    ill_q  <= !legal;
                    res_q  <= is_shift ? bus.a : alu_val;
                end
                SHIFT: begin
                    cnt_q <= cnt_q - SHW'(1);
                    case (op_q)
                        4'b0100: res_q <= {res_q[WIDTH-2:0], 1'b0};
                        4'b1000: res_q <= {1'b0, res_q[WIDTH-1:1]};
                        default: res_q <= {res_q[WIDTH-1], res_q[WIDTH-1:1]};
                    endcase
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.result    = res_q;
    assign bus.zero      = (state == DONE) && (res_q == '0);
    assign bus.illegal   = (state == DONE) && ill_q;
    assign bus.lt_s      = lt_s_q;
    assign bus.lt_u      = lt_u_q;
endmodule

// File: tb/tb_alu_iter_exec.sv
// tb/tb_alu_iter_exec.sv - randomized and directed self-checking bench for alu_iter_exec
module tb_alu_iter_exec;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;

    alu_iter_exec_if #(.WIDTH(32)) bus();

    alu_iter_exec #(.WIDTH(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_res(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
        int sh;
        sh = int'(y % 32);
        case (o)
            4'd0:  return x & y;
            4'd1:  return x | y;
            4'd2:  return x + y;
            4'd3:  return x ^ y;
            4'd4:  return x << sh;
            4'd5:  return (x < y) ? 32'd1 : 32'd0;
            4'd6,
            4'd7:  return x - y;
            4'd8:  return x >> sh;
            4'd10: return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
            4'd12: return 32'($signed(x) >>> sh);
            default: return 32'd0;
        endcase
    endfunction

    function automatic bit ref_legal(input logic [3:0] o);
        return !(o == 4'd9 || o == 4'd11 || o >= 4'd13);
    endfunction

    function automatic int ref_lat(input logic [3:0] o, input logic [31:0] y);
        if ((o == 4'd4 || o == 4'd8 || o == 4'd12) && (y % 32) != 0) return 1 + int'(y % 32);
        return 1;
    endfunction

    // Entered and left just after a falling edge; stall = cycles of out_ready=0 once the result is up.
    task automatic do_op(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y, input int stall);
        logic [31:0] er;
        int lat;
        er = ref_res(o, x, y);
        chk("pre_in_ready", bus.in_ready, 1);
        bus.op = o; bus.a = x; bus.b = y; bus.in_valid = 1'b1;
        bus.out_ready = (stall == 0);
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        while (!bus.out_valid && lat < 80) begin
            @(posedge clk); lat++; @(negedge clk);
        end
        chk("out_valid", bus.out_valid, 1);
        chk("latency", lat, ref_lat(o, y));
        chk("result", bus.result, er);
        chk("zero", bus.zero, (er == 0));
        chk("lt_s", bus.lt_s, ($signed(x) < $signed(y)));
        chk("lt_u", bus.lt_u, (x < y));
        chk("illegal", bus.illegal, !ref_legal(o));
        chk("in_ready_busy", bus.in_ready, 0);
        for (int i = 0; i < stall; i++) begin
            bus.in_valid = 1'($urandom_range(0, 1));
            bus.op = 4'($urandom); bus.a = $urandom; bus.b = $urandom;
            if (i == stall - 1) bus.out_ready = 1'b1;
            @(posedge clk); @(negedge clk);
            if (i != stall - 1) begin
                chk("held_result", bus.result, er);
                chk("held_valid", bus.out_valid, 1);
                chk("held_in_ready", bus.in_ready, 0);
            end
        end
        if (stall == 0) begin
            @(posedge clk); @(negedge clk);
        end
        bus.in_valid = 1'b0;
        chk("post_valid", bus.out_valid, 0);
        chk("post_in_ready", bus.in_ready, 1);
    endtask

    initial begin
        logic [3:0] o;
        logic [31:0] x, y;
        bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        bus.op = '0; bus.a = '0; bus.b = '0;
        #2;
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_result", bus.result, 0);
        chk("rst_flags", {bus.zero, bus.lt_s, bus.lt_u, bus.illegal}, 0);
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);

        // Reset in the middle of a long left shift
        bus.op = 4'd4; bus.a = 32'h1234_5678; bus.b = 32'd20; bus.in_valid = 1'b1;
        @(posedge clk); @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (5) begin @(posedge clk); @(negedge clk); end
        chk("mid_shift_in_ready", bus.in_ready, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_in_ready", bus.in_ready, 1);
        chk("async_rst_out_valid", bus.out_valid, 0);
        chk("async_rst_result", bus.result, 0);
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);

        do_op(4'd2,  32'hFFFF_FFFF, 32'd1, 0);
        do_op(4'd6,  32'd5, 32'd7, 0);
        do_op(4'd10, 32'h8000_0000, 32'd1, 0);
        do_op(4'd5,  32'h8000_0000, 32'd1, 0);
        do_op(4'd7,  32'd99, 32'd99, 0);
        do_op(4'd12, 32'h8000_0001, 32'd4, 0);
        do_op(4'd8,  32'h8000_0001, 32'd31, 0);
        do_op(4'd4,  32'h8000_0001, 32'd0, 0);
        do_op(4'd3,  32'h0000_00F0, 32'h0000_00FF, 10);
        do_op(4'd15, 32'h1234_5678, 32'h9ABC_DEF0, 0);
        do_op(4'd0,  32'h0000_000C, 32'h0000_000A, 0);

        for (int n = 0; n < 150; n++) begin
            o = 4'($urandom);
            x = $urandom;
            y = $urandom;
            if ($urandom_range(0, 3) == 0) y = x;
            do_op(o, x, y, ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
